// File: rtl/nibble_reg_arbiter.sv
// -----------------------------------------------------------------------------
// nibble_reg_arbiter
//
// Shares one WIDTH x 4-bit packed nibble register among NREQ requesters.
// A round-robin arbiter picks one valid requester while idle. It accepts that
// requester's data with a one-hot valid/ready handshake. On the following clock
// edge the captured value is committed into the shared register. So the design
// is a fair, sequenced single writer, and it sustains at most one write every
// two clocks.
//
// Optional feature (macro NIBBLE_REG_ARB_MASK_EN):
//   Adds a per-lane write mask input, which is captured together with the data.
//   A commit writes only the lanes whose mask bit is 1. An all-zero mask still
//   counts as a commit: out_valid pulses and out_owner updates.
//   When the macro is undefined there is no req_mask port, and every commit
//   writes all lanes.
//
// Ports:
//   clk        in   1                         clock, rising edge
//   reset      in   1                         synchronous, active-high
//   req_valid  in   [NREQ-1:0]                requester i has a write pending
//   req_data   in   [NREQ-1:0][WIDTH-1:0][3:0] write value per requester
//   req_mask   in   [NREQ-1:0][WIDTH-1:0]     per-lane write enable (mask build only)
//   req_ready  out  [NREQ-1:0]                one-hot accept; transfer = valid & ready
//   out        out  [WIDTH-1:0][3:0]          shared register contents
//   out_valid  out  1                         one-cycle pulse: out updated this cycle
//   out_owner  out  [IDXW-1:0]                index of the last committed writer
//   busy       out  1                         high while a commit is pending
// -----------------------------------------------------------------------------
module nibble_reg_arbiter #(
  parameter int                     WIDTH       = 8,
  parameter int                     NREQ        = 4,
  parameter logic [WIDTH-1:0][3:0]  RESET_VALUE = '0,
  localparam int                    IDXW        = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NREQ-1:0]                   req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0][3:0]   req_data,
`ifdef NIBBLE_REG_ARB_MASK_EN
  input  logic [NREQ-1:0][WIDTH-1:0]        req_mask,
`endif
  output logic [NREQ-1:0]                   req_ready,
  output logic [WIDTH-1:0][3:0]             out,
  output logic                              out_valid,
  output logic [IDXW-1:0]                   out_owner,
  output logic                              busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  // rr_ptr holds the most recent winner. The scan starts just past it, so a
  // requester that has just been served drops to lowest priority.
  logic [IDXW-1:0]          rr_ptr;

  // Arbitration result
  logic                     grant_found;
  logic [IDXW-1:0]          grant_idx;
  logic [IDXW-1:0]          scan_idx;
  logic                     transfer;

  // Write captured on the accept edge and committed on the next edge
  logic [WIDTH-1:0][3:0]    cap_data;
  logic [IDXW-1:0]          cap_idx;
  logic [WIDTH-1:0][3:0]    commit_value;
`ifdef NIBBLE_REG_ARB_MASK_EN
  logic [WIDTH-1:0]         cap_mask;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin scan. The offsets run rr_ptr+1 .. rr_ptr+NREQ modulo NREQ. The
  // last offset revisits rr_ptr itself, so a lone requester is still served.
  // The modulo keeps the scan correct when NREQ is not a power of two.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal is given a default before the loop. A path that left
    // one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IDXW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and handshake outputs. req_ready is combinational from
  // req_valid while IDLE. Because the winner is always a valid requester, a
  // grant in IDLE is also a transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = 1'b0;
    transfer  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready = NREQ'(1) << grant_idx;
          transfer  = 1'b1;
          state_d   = COMMIT;
        end
      end
      COMMIT: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit value. In the mask build, lanes with a cleared mask bit keep the
  // current register contents.
  // ---------------------------------------------------------------------------
`ifdef NIBBLE_REG_ARB_MASK_EN
  always_comb begin
    commit_value = out;
    for (int l = 0; l < WIDTH; l++) begin
      if (cap_mask[l]) begin
        commit_value[l] = cap_data[l];
      end
    end
  end
`else
  always_comb begin
    commit_value = cap_data;
  end
`endif

  // ---------------------------------------------------------------------------
  // State, pointer and output register. Reset takes priority over everything,
  // including a commit or a transfer on the same edge. A captured write that is
  // pending at reset is therefore dropped and never raises out_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: all sequential state uses non-blocking assignments. Every register
    // then samples its pre-edge inputs, whatever order the statements are in.
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= IDXW'(NREQ - 1);
      out       <= RESET_VALUE;
      out_owner <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      if (transfer) begin
        rr_ptr <= grant_idx;
      end
      if (state_q == COMMIT) begin
        out       <= commit_value;
        out_owner <= cap_idx;
        out_valid <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Capture of the accepted write. Data is sampled only on the accept edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: these data-path registers are intentionally left without reset.
    // They are read only in COMMIT, and COMMIT is reachable only through a
    // transfer that loads them first.
    if (transfer) begin
      cap_data <= req_data[grant_idx];
      cap_idx  <= grant_idx;
`ifdef NIBBLE_REG_ARB_MASK_EN
      cap_mask <= req_mask[grant_idx];
`endif
    end
  end

endmodule

// File: tb/tb_nibble_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nibble_reg_arbiter
//
// Directed testbench for nibble_reg_arbiter (WIDTH=8, NREQ=4,
// RESET_VALUE=32'h1234_5678).
//
// A behavioural model tracks the following items:
//   - the last grantee,
//   - whether a write is pending and what it holds,
//   - the expected register contents.
// A compare process checks every DUT output against this model on each falling
// edge. The directed sequences also check hand-computed literal values, and
// they check the grant and owner orders that the model and the DUT record.
// The mask scenario is compiled only when NIBBLE_REG_ARB_MASK_EN is defined.
// -----------------------------------------------------------------------------
module tb_nibble_reg_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDXW  = 2;
  localparam int LANEW = 3;
  localparam logic [WIDTH-1:0][3:0] RV = 32'h1234_5678;

  logic                            clk = 1'b0;
  logic                            reset = 1'b1;
  logic [NREQ-1:0]                 req_valid = '0;
  logic [NREQ-1:0][WIDTH-1:0][3:0] req_data = '0;
`ifdef NIBBLE_REG_ARB_MASK_EN
  logic [NREQ-1:0][WIDTH-1:0]      req_mask = '1;
`endif
  logic [NREQ-1:0]                 req_ready;
  logic [WIDTH-1:0][3:0]           out;
  logic                            out_valid;
  logic [IDXW-1:0]                 out_owner;
  logic                            busy;

  nibble_reg_arbiter #(
    .WIDTH       (WIDTH),
    .NREQ        (NREQ),
    .RESET_VALUE (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
`ifdef NIBBLE_REG_ARB_MASK_EN
    .req_mask  (req_mask),
`endif
    .req_ready (req_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_owner (out_owner),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int                    m_last   = NREQ - 1;
  bit                    m_pend   = 1'b0;
  logic [WIDTH-1:0][3:0] m_pdata  = '0;
  logic [WIDTH-1:0]      m_pmask  = '1;
  int                    m_pidx   = 0;
  logic [WIDTH-1:0][3:0] m_out    = RV;
  int                    m_owner  = 0;
  bit                    m_ovalid = 1'b0;
  int                    grant_q[$];
  int                    owner_q[$];

  // This returns the first valid requester after the last grantee, with
  // wrap-around, or -1 when no requester is valid.
  function automatic int model_winner();
    for (int k = 1; k <= NREQ; k++) begin
      if (req_valid[IDXW'((m_last + k) % NREQ)]) return (m_last + k) % NREQ;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_last   = NREQ - 1;
        m_pend   = 1'b0;
        m_out    = RV;
        m_owner  = 0;
        m_ovalid = 1'b0;
      end else if (m_pend) begin
        for (int l = 0; l < WIDTH; l++) begin
          if (m_pmask[LANEW'(l)]) m_out[LANEW'(l)] = m_pdata[LANEW'(l)];
        end
        m_owner  = m_pidx;
        m_ovalid = 1'b1;
        m_pend   = 1'b0;
      end else begin
        int w;
        m_ovalid = 1'b0;
        w = model_winner();
        if (w >= 0) begin
          m_pend  = 1'b1;
          m_pidx  = w;
          m_last  = w;
          m_pdata = req_data[IDXW'(w)];
`ifdef NIBBLE_REG_ARB_MASK_EN
          m_pmask = req_mask[IDXW'(w)];
`else
          m_pmask = '1;
`endif
          grant_q.push_back(w);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare on the falling edge
  // ---------------------------------------------------------------------------
  int              cmp_w;
  logic [NREQ-1:0] cmp_ready;

  initial begin
    forever begin
      @(negedge clk);
      cmp_w     = model_winner();
      cmp_ready = (!m_pend && cmp_w >= 0) ? (NREQ'(1) << cmp_w) : '0;
      check("cyc_req_ready", req_ready, cmp_ready);
      check("cyc_busy",      busy,      m_pend);
      check("cyc_out",       out,       m_out);
      check("cyc_out_valid", out_valid, m_ovalid);
      check("cyc_out_owner", out_owner, m_owner);
      if (out_valid === 1'b1) owner_q.push_back(int'(out_owner));
    end
  end

  // This task advances to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // This task moves to the falling edge of the current cycle.
  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    int exp3[5];
    int exp4[3];
    int exp7[3];
    exp3 = '{0, 1, 2, 3, 0};
    exp4 = '{3, 1, 3};
    exp7 = '{1, 1, 1};

    // 1. Reset held for two clocks
    step(); step(); settle();
    check("rst_out",       out,       32'h1234_5678);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_req_ready", req_ready, 4'b0000);
    check("rst_out_owner", out_owner, 2'd0);

    // 2. Single request from requester 2
    step();
    reset       = 1'b0;
    req_valid   = 4'b0100;
    req_data[2] = 32'hDEAD_BEEF;
    settle();
    check("single_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b0000;
    settle();
    check("single_busy", busy, 1'b1);
    check("single_ready_commit", req_ready, 4'b0000);
    step(); settle();
    check("single_out",   out,       32'hDEAD_BEEF);
    check("single_owner", out_owner, 2'd2);
    check("single_pulse", out_valid, 1'b1);
    step(); settle();
    check("single_pulse_end", out_valid, 1'b0);
    check("single_hold",      out,       32'hDEAD_BEEF);

    // 3. All four requesters are continuously valid, starting from reset
    step();
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    grant_q.delete();
    owner_q.delete();
    repeat (10) step();
    req_valid = 4'b0000;
    step();
    check("rr_grant_count", grant_q.size(), 5);
    check("rr_owner_count", owner_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_grant_%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, exp3[i]);
      check($sformatf("rr_owner_%0d", i), (i < owner_q.size()) ? owner_q[i] : -1, exp3[i]);
    end

    // 4. Wrap: grant 3 first, then only requesters 1 and 3 are valid
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 4'b1000;
    grant_q.delete();
    step();
    req_valid = 4'b1010;
    step(); step(); step(); step();
    req_valid = 4'b0000;
    step();
    check("wrap_count", grant_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wrap_grant_%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, exp4[i]);
    end

    // 5. Reset while a captured all-ones write is pending
    req_valid   = 4'b0001;
    req_data[0] = 32'hFFFF_FFFF;
    step();
    reset     = 1'b1;
    req_valid = 4'b0000;
    settle();
    check("rstc_busy_before", busy, 1'b1);
    step(); settle();
    check("rstc_out",       out,       32'h1234_5678);
    check("rstc_out_valid", out_valid, 1'b0);
    check("rstc_busy",      busy,      1'b0);
    step();
    reset       = 1'b0;
    req_valid   = 4'b0011;
    req_data[0] = 32'h0F0F_0F0F;
    req_data[1] = 32'h1111_1111;
    settle();
    check("rstc_first_grant", req_ready, 4'b0001);
    step();
    req_valid = 4'b0000;
    step(); settle();
    check("rstc_out_after",   out,       32'h0F0F_0F0F);
    check("rstc_owner_after", out_owner, 2'd0);

    // 6. A lone, continuously valid requester is granted every other cycle
    step();
    grant_q.delete();
    req_valid = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      req_data[1] = 32'h0000_0100 + i;
      step();
    end
    req_valid = 4'b0000;
    step();
    check("lone_count", grant_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lone_grant_%0d", i), (i < grant_q.size()) ? grant_q[i] : -1, exp7[i]);
    end

`ifdef NIBBLE_REG_ARB_MASK_EN
    // 7. Masked lane writes
    req_valid   = 4'b0001;
    req_data[0] = 32'h0000_0000;
    req_mask[0] = 8'hFF;
    step();
    req_valid = 4'b0000;
    step(); settle();
    check("mask_clear", out, 32'h0000_0000);
    step();
    req_valid   = 4'b0001;
    req_data[0] = 32'hAAAA_AAAA;
    req_mask[0] = 8'h0F;
    step();
    req_valid = 4'b0000;
    step(); settle();
    check("mask_low", out, 32'h0000_AAAA);
    step();
    req_valid   = 4'b0100;
    req_data[2] = 32'h5555_5555;
    req_mask[2] = 8'h00;
    step();
    req_valid = 4'b0000;
    step(); settle();
    check("mask_zero_out",   out,       32'h0000_AAAA);
    check("mask_zero_pulse", out_valid, 1'b1);
    check("mask_zero_owner", out_owner, 2'd2);
    step();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
